sprite_blitter: RTL

- Downstream consumer of the 8x8 sprite buffer's read stream.
- Accepts a draw command with signed screen position (x, y).
- Kicks the sprite buffer into its 64-cycle read burst and converts each pixel, already in display orientation and row-major order, into a framebuffer write.
- Applies colour-key transparency and screen-edge clipping.
- Sits between the sprite command sequencer and the framebuffer write port.

---
 rtl/sprite_blitter_pkg.sv | 30 +++
 rtl/sprite_blitter_addr_gen.sv | 33 +++
 rtl/sprite_blitter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/sprite_blitter_pkg.sv
// Shared types and constants for the sprite path (buffer, sequencer, blitter).
// No logic; latency n/a.
// Backpressure n/a.
package sprite_blitter_pkg;

    localparam int SPRITE_DIM = 8;
    localparam int SPRITE_PX  = 64;

    // Orientation is applied inside the sprite buffer; the blitter only sees display order.
    typedef enum logic [1:0] {
        ORIENT_NORMAL,
        ORIENT_FLIP_H,
        ORIENT_FLIP_V,
        ORIENT_ROT180
    } orient_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        STREAM,
        LAST
    } blit_state_t;

endpackage

// File: rtl/sprite_blitter_addr_gen.sv
// Screen-space clip test and framebuffer address for one sprite pixel.
// Purely combinational; the parent registers the outputs.
// Backpressure n/a.
module blit_addr_gen
    import sprite_blitter_pkg::*;
#(
    parameter int FB_W   = 320,
    parameter int FB_H   = 240,
    parameter int ADDR_W = 17
) (
    input  logic signed [10:0]                    x,
    input  logic signed [10:0]                    y,
    input  logic [$clog2(SPRITE_DIM)-1:0]         row,
    input  logic [$clog2(SPRITE_DIM)-1:0]         col,
    output logic                                  in_bounds,
    output logic [ADDR_W-1:0]                     fb_addr
);

    localparam logic signed [10:0] FB_W_S = 11'(FB_W);
    localparam logic signed [10:0] FB_H_S = 11'(FB_H);

    logic signed [10:0] sx;
    logic signed [10:0] sy;

    always_comb begin
        sx = x + $signed({8'b0, col});
        sy = y + $signed({8'b0, row});
        // Negative and past-the-edge coordinates are rejected outright so nothing wraps a row.
        in_bounds = !sx[10] && (sx < FB_W_S) && !sy[10] && (sy < FB_H_S);
        fb_addr   = ADDR_W'(sy[9:0]) * ADDR_W'(FB_W) + ADDR_W'(sx[9:0]);
    end

endmodule

// File: rtl/sprite_blitter.sv
// Turns the 64-pixel sprite buffer stream into clipped, colour-keyed framebuffer writes.
// Latency: buf_read 1 cycle after start, pixel k written 3+k cycles after start, done at 66.
// Backpressure: none; the framebuffer must take one write per cycle, starts ignored while busy.
module sprite_blitter
    import sprite_blitter_pkg::*;
#(
    parameter int          FB_W       = 320,
    parameter int          FB_H       = 240,
    parameter int          ADDR_W     = 17,
    parameter logic [23:0] TRANSP_KEY = 24'hFF00FF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic signed [10:0] x,
    input  logic signed [10:0] y,
    input  logic               transp_en,
    output logic               busy,
    output logic               done,
    output logic               buf_read,
    input  logic [7:0]         buf_r,
    input  logic [7:0]         buf_g,
    input  logic [7:0]         buf_b,
    output logic               fb_we,
    output logic [ADDR_W-1:0]  fb_addr,
    output logic [23:0]        fb_data
);

    blit_state_t        state;
    blit_state_t        state_nxt;
    logic [5:0]         k;
    logic signed [10:0] x_l;
    logic signed [10:0] y_l;
    logic               transp_l;

    rgb_t               pixel;
    logic               in_bounds;
    logic [ADDR_W-1:0]  addr_nxt;
    logic               keyed;

    assign pixel = '{r: buf_r, g: buf_g, b: buf_b};
    assign keyed = transp_l && (pixel == TRANSP_KEY);

    blit_addr_gen #(
        .FB_W   (FB_W),
        .FB_H   (FB_H),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .x         (x_l),
        .y         (y_l),
        .row       (k[5:3]),
        .col       (k[2:0]),
        .in_bounds (in_bounds),
        .fb_addr   (addr_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        buf_read  = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = REQ;
            end
            REQ: begin
                busy      = 1'b1;
                buf_read  = 1'b1;
                state_nxt = STREAM;
            end
            STREAM: begin
                busy = 1'b1;
                if (k == 6'(SPRITE_PX - 1)) state_nxt = LAST;
            end
            LAST: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k        <= '0;
            x_l      <= '0;
            y_l      <= '0;
            transp_l <= 1'b0;
            fb_we    <= 1'b0;
            fb_addr  <= '0;
            fb_data  <= '0;
        end else begin
            if (state == IDLE && start) begin
                x_l      <= x;
                y_l      <= y;
                transp_l <= transp_en;
            end
            if (state == REQ) begin
                k <= '0;
            end else if (state == STREAM) begin
                k <= k + 6'd1;
            end
            // Address and data stay put on skipped slots; only fb_we marks a real write.
            fb_we <= 1'b0;
            if (state == STREAM && in_bounds && !keyed) begin
                fb_we   <= 1'b1;
                fb_addr <= addr_nxt;
                fb_data <= pixel;
            end
        end
    end

endmodule
